// File: rtl/uart_rx_device_if.sv
// Simple memory bus between a bus master and the UART receiver device.
// Reads and writes are single-cycle: an access is taken at the posedge where ren/wen is high, rdata is combinational.
interface uart_rx_device_if;
  logic [31:0] addr;
  logic        ren;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;

  modport master (output addr, ren, wdata, wen, wstrb, input rdata);
  modport slave  (input addr, ren, wdata, wen, wstrb, output rdata);
endinterface

// File: rtl/uart_rx_device.sv
// Memory-mapped 8N1 UART receiver: synchronised rx, bit-timing FSM, byte FIFO,
// RXDATA (pop on read) and STATUS (W1C ovr/ferr) registers.
module uart_rx_device #(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DATA_OFF   = 16'h0004,
  parameter logic [15:0] STAT_OFF   = 16'h0008
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_device_if.slave        bus,
  input  logic                   rx,
  output logic [2:0]             state_dbg
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] CNT_FULL = FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FW-1:0]   count;
  logic            ovr, ferr;

  logic at_half, at_last, stop_sample, push, frame_err;
  logic data_hit, stat_hit, valid, full, pop, push_ok, ovr_set, clr;

  // Bits of the bus this device never decodes.
  logic unused_bus;
  assign unused_bus = ^{bus.addr[31:16], bus.wdata[31:4], bus.wdata[1:0], bus.wstrb[3:1]};

  assign state_dbg = state;

  assign at_half     = (cnt == CNT_HALF);
  assign at_last     = (cnt == CNT_LAST);
  assign stop_sample = (state == S_STOP) && at_last;
  assign push        = stop_sample && rx_s;
  assign frame_err   = stop_sample && !rx_s;

  assign data_hit = (bus.addr[15:0] == DATA_OFF);
  assign stat_hit = (bus.addr[15:0] == STAT_OFF);
  assign valid    = (count != '0);
  assign full     = (count == CNT_FULL);
  assign pop      = bus.ren && data_hit && valid;
  // A full FIFO still accepts a byte if a read frees a slot on the same edge.
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign clr      = bus.wen && stat_hit && bus.wstrb[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (at_half) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (at_last) begin
            cnt <= '0;
            sh  <= {rx_s, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (at_last) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // Line held low after a bad stop bit must go high before a new start is accepted.
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + FW'(1);
        2'b01:   count <= count - FW'(1);
        default: ;
      endcase
      // A new set on the same edge as a W1C clear wins.
      ovr  <= ovr_set   | (ovr  & ~(clr & bus.wdata[2]));
      ferr <= frame_err | (ferr & ~(clr & bus.wdata[3]));
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.ren) begin
      if (data_hit) begin
        if (valid) bus.rdata = {24'h0, mem[rd_ptr]};
      end else if (stat_hit) begin
        bus.rdata = {28'h0, ferr, ovr, full, valid};
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_device.sv
// Bench for uart_rx_device: serial frames driven on rx, received bytes checked
// against an expected queue on RXDATA reads, STATUS checked against constants.
module tb_uart_rx_device;

  localparam int          CLK_DIV    = 16;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [15:0] DATA_OFF   = 16'h0004;
  localparam logic [15:0] STAT_OFF   = 16'h0008;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] state_dbg;

  uart_rx_device_if bus ();

  uart_rx_device #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .DATA_OFF(DATA_OFF), .STAT_OFF(STAT_OFF)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rx(rx), .state_dbg(state_dbg)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [7:0] exp_q[$];
  logic       exp_ovr;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic sb_push(input logic [7:0] b);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // Drivers (all tasks start and end 1 time unit after a posedge)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(CLK_DIV);
  endtask

  task automatic send_bits(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    drive_bit(1'b1);
  endtask

  task automatic bus_read(input logic [15:0] off, output logic [31:0] d);
    bus.addr = {16'h0, off};
    bus.ren  = 1'b1;
    #1;
    d = bus.rdata;
    @(posedge clk);
    #1;
    bus.ren  = 1'b0;
    bus.addr = 32'h0;
  endtask

  task automatic bus_write(input logic [15:0] off, input logic [31:0] data, input logic [3:0] strb);
    bus.addr  = {16'h0, off};
    bus.wdata = data;
    bus.wstrb = strb;
    bus.wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.wen   = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wstrb = 4'h0;
  endtask

  // Tests
  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    bus.addr = {16'h0, STAT_OFF};
    #1;
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata_ren0: got %h expected 00000000", bus.rdata);
    end
    bus.addr = 32'h0;
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_status: got %h expected 00000000", d);
    end
    bus_read(DATA_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 00000000", d);
    end
  endtask

  task automatic test_single;
    logic [31:0] d;
    logic [7:0]  e;
    send_byte(8'h48);
    sb_push(8'h48);
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL single_status: got %h expected 00000001", d);
    end
    bus_read(DATA_OFF, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== {24'h0, e}) begin
      n_err++; $display("FAIL single_data: got %h expected %h", d, {24'h0, e});
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL single_status_after: got %h expected 00000000", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [7:0]  e;
    logic [7:0]  msg [6];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
    for (int i = 0; i < 6; i++) begin
      send_byte(msg[i]);
      sb_push(msg[i]);
    end
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL b2b_status: got %h expected 00000001", d);
    end
    for (int i = 0; i < 6; i++) begin
      bus_read(DATA_OFF, d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin
        n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, {24'h0, e});
      end
    end
    bus_read(DATA_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL b2b_empty_read: got %h expected 00000000", d);
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL b2b_status_after: got %h expected 00000000", d);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic [7:0]  e;
    exp_ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(i));
      sb_push(8'(i));
    end
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== {29'h0, exp_ovr, 2'b11}) begin
      n_err++; $display("FAIL ovf_status: got %h expected %h", d, {29'h0, exp_ovr, 2'b11});
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      bus_read(DATA_OFF, d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin
        n_err++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, d, {24'h0, e});
      end
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL ovf_status_drained: got %h expected 00000004", d);
    end
    bus_write(STAT_OFF, 32'h4, 4'h0);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL ovf_no_strobe: got %h expected 00000004", d);
    end
    bus_write(STAT_OFF, 32'h4, 4'h1);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL ovf_w1c: got %h expected 00000000", d);
    end
  endtask

  task automatic test_frame_error;
    logic [31:0] d;
    logic [7:0]  e;
    send_bits(8'h55);
    rx = 1'b0;
    tick(30);
    n_cmp++;
    if (state_dbg !== 3'd4) begin
      n_err++; $display("FAIL ferr_break_state: got %0d expected 4", state_dbg);
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++; $display("FAIL ferr_status_low: got %h expected 00000008", d);
    end
    tick(9);
    rx = 1'b1;
    tick(20);
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++; $display("FAIL ferr_idle_state: got %0d expected 0", state_dbg);
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++; $display("FAIL ferr_status_high: got %h expected 00000008", d);
    end
    send_byte(8'hA5);
    sb_push(8'hA5);
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h9) begin
      n_err++; $display("FAIL ferr_status_next: got %h expected 00000009", d);
    end
    bus_read(DATA_OFF, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== {24'h0, e}) begin
      n_err++; $display("FAIL ferr_next_data: got %h expected %h", d, {24'h0, e});
    end
    bus_write(STAT_OFF, 32'h8, 4'h1);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL ferr_w1c: got %h expected 00000000", d);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++; $display("FAIL glitch_state: got %0d expected 0", state_dbg);
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL glitch_status: got %h expected 00000000", d);
    end
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [7:0]  b, e;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      sb_push(b);
    end
    tick(2);
    for (int i = 0; i < 4; i++) begin
      bus_read(DATA_OFF, d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin
        n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", i, d, {24'h0, e});
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    logic [7:0]  e;
    drive_bit(1'b0);
    rx = 1'b1;
    tick(40);
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_err++; $display("FAIL midrst_in_data: got %0d expected 2", state_dbg);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    tick(20);
    send_byte(8'h3C);
    sb_push(8'h3C);
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL midrst_status: got %h expected 00000001", d);
    end
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h10 + 8'(i));
      sb_push(8'h10 + 8'(i));
    end
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL midrst_full: got %h expected 00000003", d);
    end
    // Read lands on the same edge as the stop-bit sample of the ninth byte.
    fork
      send_byte(8'h17);
      begin
        int w = 0;
        while (state_dbg !== 3'd3 && w < 400) begin
          @(posedge clk);
          #1;
          w++;
        end
        n_cmp++;
        if (state_dbg !== 3'd3) begin
          n_err++; $display("FAIL coincide_wait_stop: got state %0d expected 3", state_dbg);
        end else begin
          tick(CLK_DIV - 1);
          bus_read(DATA_OFF, d);
          e = exp_q.pop_front();
          exp_q.push_back(8'h17);
          n_cmp++;
          if (d !== {24'h0, e}) begin
            n_err++; $display("FAIL coincide_data: got %h expected %h", d, {24'h0, e});
          end
        end
      end
    join
    tick(2);
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL coincide_status: got %h expected 00000003", d);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      bus_read(DATA_OFF, d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      n_cmp++;
      if (d !== {24'h0, e}) begin
        n_err++; $display("FAIL coincide_drain[%0d]: got %h expected %h", i, d, {24'h0, e});
      end
    end
    bus_read(STAT_OFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL coincide_status_end: got %h expected 00000000", d);
    end
  endtask

  // Sequence and report
  initial begin
    rst       = 1'b1;
    rx        = 1'b1;
    exp_ovr   = 1'b0;
    bus.addr  = 32'h0;
    bus.ren   = 1'b0;
    bus.wen   = 1'b0;
    bus.wdata = 32'h0;
    bus.wstrb = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_frame_error();
    test_glitch();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
